add_seq64: RTL
==============

ADD_SEQ64 -- requirements
Module: add_seq64

Interface
REQ-001 SHALL have parameter SUB_EN, default 1, meaning subtract mode is enabled; when 0 the sub input is ignored and treated as 0.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand request is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have ports a and b, input, 64 bits each: the operands.
REQ-007 SHALL have port sub, input, 1 bit: 1 selects a-b, 0 selects a+b+cin.
REQ-008 SHALL have port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port sum, output, 64 bits: the result.
REQ-012 SHALL have ports cout (carry out of bit 63) and ovf (signed overflow), output, 1 bit each.

Function
REQ-013 SHALL compute the 64-bit result by reusing one combinational 16-bit carry-lookahead slice over 4 sequential beats, LSB slice first.
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready SHALL latch a, b' = sub ? ~b : b, and carry = sub ? 1 : cin; beat counter=0; next state RUN.
REQ-016 RUN: each cycle SHALL add slice k of a and b' plus the carry register, write sum[16k+15:16k], and register the slice carry-out as the next carry; k increments by 1.
REQ-017 After the beat with k=3, SHALL register cout = slice carry-out, ovf = (carry into bit 63) XOR (carry out of bit 63), and go to DONE.
REQ-018 Latency: out_valid SHALL rise exactly 4 clock edges after the accepting edge.
REQ-019 DONE: out_valid=1; sum, cout and ovf SHALL stay stable until out_valid&&out_ready, then the state SHALL go to IDLE.
REQ-020 in_ready SHALL equal (state==IDLE); in_valid in RUN or DONE SHALL be ignored; no accept in the same cycle as a result handoff.
REQ-021 out_ready while out_valid=0 SHALL be ignored.
REQ-022 sum SHALL change only on RUN beats; slices not yet written in the current operation hold their previous values.
REQ-023 Arithmetic SHALL be modulo 2^64; for sub, cout=1 means no borrow.
REQ-024 The beat counter is 2 bits and SHALL wrap to 0 on leaving RUN.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, counter=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0, and in_ready=1 after release, including when asserted mid-RUN or in DONE.
REQ-026 An operation interrupted by reset SHALL be discarded; no out_valid is produced for it.

Structure
REQ-027 A shared package SHALL hold WORD_W=16, NBEATS=4, DATA_W=64 and the state enum (IDLE, RUN, DONE).
REQ-028 SHALL instantiate exactly one sub-module, cla16_comb: purely combinational 16-bit CLA (4-bit lookahead groups), with inputs a, b and cin, and outputs sum, cout and c15 (carry into bit 15).
REQ-029 All registers SHALL be in add_seq64; RTL target is 150-250 lines total.

Verification
REQ-030 a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0, cin=0 -> sum=0, cout=1, ovf=0, out_valid 4 cycles after accept.
REQ-031 a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-032 a=5, b=7, sub=1, cin=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0 (cin ignored).
REQ-033 a=0x0000_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0x0001_0000_0000_0000 (carry crosses 3 slice boundaries).
REQ-034 Hold out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands -> sum, cout and ovf are unchanged and in_ready=0; the queued request is accepted only after handoff plus 1 cycle.
REQ-035 Assert rst during beat k=2 -> out_valid=0, sum=0 and in_ready=1 after release; a following request a=1, b=2 -> sum=3.

Source files
------------

// File: rtl/add_seq64_pkg.sv
// add_seq64_pkg: shared widths, beat count and FSM state type for the
// sequential 64-bit adder built from a reused 16-bit carry-lookahead slice.
package add_seq64_pkg;

    localparam int unsigned WORD_W = 16;                 // slice width
    localparam int unsigned NBEATS = 4;                  // slices per operation
    localparam int unsigned DATA_W = 64;                 // operand width
    localparam int unsigned CNT_W  = $clog2(NBEATS);     // beat counter width
    localparam int unsigned LO_W   = $clog2(DATA_W);     // bit-offset width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit offset of the least significant bit of slice k.
    function automatic logic [LO_W-1:0] slice_lo(input logic [CNT_W-1:0] k);
        return LO_W'(k) * LO_W'(WORD_W);
    endfunction

endpackage

// File: rtl/cla16_comb.sv
// cla16_comb: purely combinational 16-bit carry-lookahead adder built from
// four 4-bit lookahead groups and a second-level group-carry unit.
// Ports:
//   a, b  : 16-bit operands
//   cin   : carry into bit 0
//   sum   : 16-bit result
//   cout  : carry out of bit 15
//   c15   : carry into bit 15 (used for signed overflow)
module cla16_comb
    import add_seq64_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout,
    output logic              c15
);

    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] c;
    logic [3:0]        gg;
    logic [3:0]        gp;
    logic [3:0]        gc;

    assign g = a & b;
    assign p = a ^ b;

    // Group generate / propagate for each 4-bit group.
    always_comb begin
        gg = '0;
        gp = '0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
    end

    // Second-level lookahead: carry into each group.
    always_comb begin
        gc    = '0;
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
    end

    // Bit carries inside each group from the group carry-in.
    always_comb begin
        c = '0;
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
    end

    assign cout = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & cin);
    assign c15  = c[WORD_W-1];
    assign sum  = p ^ c;

endmodule

// File: rtl/add_seq64.sv
// add_seq64: 64-bit add/subtract computed over four beats by one shared
// 16-bit CLA slice, LSB slice first, with valid/ready on both sides.
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready  : request handshake (in_ready high only in IDLE)
//   a, b, sub, cin      : operands; sub=1 gives a-b, sub=0 gives a+b+cin
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   sum, cout, ovf      : result, carry out of bit 63, signed overflow
module add_seq64
    import add_seq64_pkg::*;
#(
    parameter bit SUB_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              ovf
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;            // holds ~b when subtracting
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic              sub_c;
    logic [LO_W-1:0]   lo_c;
    logic [WORD_W-1:0] slice_sum_c;
    logic              slice_cout_c;
    logic              slice_c15_c;

    assign sub_c = SUB_EN & sub;
    assign lo_c  = slice_lo(cnt_q);

    // Shared slice: operands selected by the beat counter.
    cla16_comb u_cla16 (
        .a    (a_q[lo_c +: WORD_W]),
        .b    (b_q[lo_c +: WORD_W]),
        .cin  (carry_q),
        .sum  (slice_sum_c),
        .cout (slice_cout_c),
        .c15  (slice_c15_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub_c ? ~b : b;
                    carry_d = sub_c ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[lo_c +: WORD_W] = slice_sum_c;
                carry_d               = slice_cout_c;
                // Counter wraps to 0 as the last beat completes.
                cnt_d                 = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NBEATS - 1)) begin
                    cout_d  = slice_cout_c;
                    ovf_d   = slice_c15_c ^ slice_cout_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
